// File: rtl/loteria_pkg.sv
// Shared constants, state encoding and helpers for the two-player lottery scorer.
package loteria_pkg;

    localparam int unsigned NUM_W    = 4;
    localparam int unsigned SCORE_W  = 5;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned MASK_W   = 16;
    localparam int unsigned MAX_BETS = 5;
    localparam int unsigned N_DRAWN  = 5;
    localparam int unsigned PREMIO_W = 2;

    typedef enum logic [1:0] {
        P1     = 2'd0,
        P2     = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [NUM_W-1:0] DRAWN [N_DRAWN] = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11};

    localparam logic [PREMIO_W-1:0] PREMIO_NONE = 2'b00;
    localparam logic [PREMIO_W-1:0] PREMIO_P1   = 2'b01;
    localparam logic [PREMIO_W-1:0] PREMIO_P2   = 2'b10;
    localparam logic [PREMIO_W-1:0] PREMIO_TIE  = 2'b11;

    // True when n belongs to the drawn set.
    function automatic logic is_drawn(input logic [NUM_W-1:0] n);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(N_DRAWN); i++) begin
            if (DRAWN[i] == n) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/loteria_player.sv
// Per-player bet tracker: seen mask, distinct-bet count and score accumulator.
module loteria_player
    import loteria_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [NUM_W-1:0]   numero,
    output logic [SCORE_W-1:0] score
);

    logic [MASK_W-1:0] mask;
    logic [CNT_W-1:0]  count;
    logic              accept_c;

    // Repeats are dropped first so a held strobe never consumes a bet slot.
    assign accept_c = enable && !mask[numero] && (count < CNT_W'(MAX_BETS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask  <= '0;
            count <= '0;
            score <= '0;
        end else if (clear) begin
            mask  <= '0;
            count <= '0;
            score <= '0;
        end else if (accept_c) begin
            mask[numero] <= 1'b1;
            count        <= count + CNT_W'(1);
            if (is_drawn(numero)) score <= score + SCORE_W'(numero);
        end
    end

endmodule

// File: rtl/loteria.sv
// Two-player lottery controller: turn FSM, per-player scoring and prize register.
module loteria
    import loteria_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_W-1:0]    numero,
    input  logic                insere,
    input  logic                fim,
    input  logic                fim_jogo,
    output logic [PREMIO_W-1:0] premio,
    output logic [SCORE_W-1:0]  p1,
    output logic [SCORE_W-1:0]  p2
);

    state_t                state_q;
    state_t                state_d;
    logic                  en1_c;
    logic                  en2_c;
    logic                  clear_c;
    logic [PREMIO_W-1:0]   premio_d;

    loteria_player u_player1 (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_c),
        .enable (en1_c),
        .numero (numero),
        .score  (p1)
    );

    loteria_player u_player2 (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_c),
        .enable (en2_c),
        .numero (numero),
        .score  (p2)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= P1;
            premio  <= PREMIO_NONE;
        end else begin
            state_q <= state_d;
            premio  <= premio_d;
        end
    end

    // Insert is credited in the same cycle as a turn change; fim_jogo wins over fim.
    always_comb begin
        state_d  = state_q;
        en1_c    = 1'b0;
        en2_c    = 1'b0;
        clear_c  = 1'b0;
        premio_d = PREMIO_NONE;
        case (state_q)
            P1: begin
                en1_c = insere;
                if (fim_jogo)  state_d = RESULT;
                else if (fim)  state_d = P2;
            end
            P2: begin
                en2_c = insere;
                if (fim_jogo || fim) state_d = RESULT;
            end
            RESULT: begin
                if (fim) begin
                    clear_c = 1'b1;
                    state_d = P1;
                end else if (p1 == '0 && p2 == '0) begin
                    premio_d = PREMIO_NONE;
                end else if (p1 > p2) begin
                    premio_d = PREMIO_P1;
                end else if (p2 > p1) begin
                    premio_d = PREMIO_P2;
                end else begin
                    premio_d = PREMIO_TIE;
                end
            end
            default: state_d = P1;
        endcase
    end

endmodule

// File: tb/tb_loteria.sv
// Directed self-checking bench for the loteria scorer.
module tb_loteria;

    logic       clock;
    logic       reset;
    logic [3:0] numero;
    logic       insere;
    logic       fim;
    logic       fim_jogo;
    logic [1:0] premio;
    logic [4:0] p1;
    logic [4:0] p2;

    int n_tests;
    int n_fail;

    loteria dut (
        .clock    (clock),
        .reset    (reset),
        .numero   (numero),
        .insere   (insere),
        .fim      (fim),
        .fim_jogo (fim_jogo),
        .premio   (premio),
        .p1       (p1),
        .p2       (p2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic insert(input logic [3:0] n, input int cycles);
        numero = n;
        insere = 1'b1;
        repeat (cycles) tick();
        insere = 1'b0;
    endtask

    task automatic pulse_fim();
        fim = 1'b1;
        tick();
        fim = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        numero   = 4'd0;
        insere   = 1'b0;
        fim      = 1'b0;
        fim_jogo = 1'b0;
        #1;
        check("reset_p1", 8'(p1), 8'd0);
        check("reset_p2", 8'(p2), 8'd0);
        check("reset_premio", 8'(premio), 8'd0);
        tick();
        reset = 1'b0;

        // Held inserts: 5+3+2 = 10, 8 and 0 count as bets but score nothing
        insert(4'd5, 2);
        check("held_5", 8'(p1), 8'd5);
        insert(4'd3, 2);
        insert(4'd8, 2);
        insert(4'd2, 2);
        insert(4'd0, 2);
        check("t1_p1", 8'(p1), 8'd10);
        check("t1_p2", 8'(p2), 8'd0);
        check("t1_premio", 8'(premio), 8'd0);
        insert(4'd7, 1);
        check("t1_sixth_ignored", 8'(p1), 8'd10);
        pulse_fim();
        pulse_fim();
        check("t1_premio_at_entry", 8'(premio), 8'd0);
        tick();
        check("t1_premio_p1", 8'(premio), 8'd1);
        pulse_fim();
        check("newgame_p1", 8'(p1), 8'd0);
        check("newgame_p2", 8'(p2), 8'd0);
        check("newgame_premio", 8'(premio), 8'd0);

        // All drawn numbers, then a sixth distinct one
        insert(4'd2, 1);
        insert(4'd3, 1);
        insert(4'd5, 1);
        insert(4'd7, 1);
        insert(4'd11, 1);
        insert(4'd13, 1);
        check("t2_max_score", 8'(p1), 8'd28);
        pulse_fim();
        insert(4'd2, 1);
        check("t2_p2_credited", 8'(p2), 8'd2);
        check("t2_p1_held", 8'(p1), 8'd28);
        pulse_fim();
        pulse_fim();

        // P1 11 vs P2 5
        insert(4'd11, 1);
        pulse_fim();
        insert(4'd2, 1);
        insert(4'd3, 1);
        pulse_fim();
        tick();
        check("t3_p1", 8'(p1), 8'd11);
        check("t3_p2", 8'(p2), 8'd5);
        check("t3_premio", 8'(premio), 8'd1);
        pulse_fim();

        // fim_jogo with a coincident insert credits P2 first
        insert(4'd5, 1);
        pulse_fim();
        insert(4'd2, 1);
        insert(4'd3, 1);
        numero   = 4'd7;
        insere   = 1'b1;
        fim_jogo = 1'b1;
        tick();
        insere   = 1'b0;
        fim_jogo = 1'b0;
        check("t4_p2", 8'(p2), 8'd12);
        tick();
        check("t4_premio", 8'(premio), 8'd2);
        insert(4'd11, 1);
        fim_jogo = 1'b1;
        tick();
        fim_jogo = 1'b0;
        check("t4_result_ignores_insere", 8'(p2), 8'd12);
        check("t4_premio_holds", 8'(premio), 8'd2);
        pulse_fim();

        // Tie with nonzero score
        insert(4'd7, 1);
        pulse_fim();
        insert(4'd7, 1);
        pulse_fim();
        tick();
        check("t5_tie", 8'(premio), 8'd3);
        pulse_fim();

        // Both zero
        insert(4'd0, 1);
        pulse_fim();
        insert(4'd0, 1);
        pulse_fim();
        tick();
        check("t6_zero_premio", 8'(premio), 8'd0);
        pulse_fim();

        // fim_jogo beats fim in P1: goes straight to RESULT
        insert(4'd3, 1);
        fim      = 1'b1;
        fim_jogo = 1'b1;
        tick();
        fim      = 1'b0;
        fim_jogo = 1'b0;
        insert(4'd5, 1);
        check("t7_no_p2_turn", 8'(p2), 8'd0);
        check("t7_premio", 8'(premio), 8'd1);
        pulse_fim();

        // Asynchronous reset mid-P2
        insert(4'd2, 1);
        pulse_fim();
        insert(4'd3, 1);
        check("t8_p2_before", 8'(p2), 8'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t8_async_p1", 8'(p1), 8'd0);
        check("t8_async_p2", 8'(p2), 8'd0);
        tick();
        reset = 1'b0;
        insert(4'd5, 1);
        check("t8_after_p1", 8'(p1), 8'd5);
        check("t8_after_p2", 8'(p2), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
